// File: rtl/id_branch_resolve_pkg.sv
// Shared types for decode-stage branch resolution.
// FSM state encoding and B-type funct3 condition codes.
package id_branch_resolve_pkg;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

endpackage

// File: rtl/id_branch_resolve_if.sv
// ID-stage branch bus: instruction fields, hazard inputs,
// redirect/stall outputs and statistics counters.
// master = pipeline side, slave = id_branch_resolve.
interface id_branch_resolve_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic             id_branch;
  logic             id_jal;
  logic             id_jalr;
  logic [2:0]       id_funct3;
  logic [31:0]      id_pc;
  logic [31:0]      id_imm;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic [31:0]      rs1_mod;
  logic [31:0]      rs2_mod;
  logic [4:0]       ID_EX_rd;
  logic             ID_EX_regwrite;
  logic             ID_EX_memread;
  logic [4:0]       EX_MEM_rd;
  logic             EX_MEM_memread;
  logic             stall;
  logic             pc_src;
  logic [31:0]      branch_target;
  logic             IF_ID_flush;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] br_taken_count;

  modport master (
    output id_valid, id_branch, id_jal, id_jalr,
    output id_funct3, id_pc, id_imm,
    output id_rs1_addr, id_rs2_addr,
    output rs1_mod, rs2_mod,
    output ID_EX_rd, ID_EX_regwrite, ID_EX_memread,
    output EX_MEM_rd, EX_MEM_memread,
    input  stall, pc_src, branch_target, IF_ID_flush,
    input  br_count, br_taken_count
  );

  modport slave (
    input  id_valid, id_branch, id_jal, id_jalr,
    input  id_funct3, id_pc, id_imm,
    input  id_rs1_addr, id_rs2_addr,
    input  rs1_mod, rs2_mod,
    input  ID_EX_rd, ID_EX_regwrite, ID_EX_memread,
    input  EX_MEM_rd, EX_MEM_memread,
    output stall, pc_src, branch_target, IF_ID_flush,
    output br_count, br_taken_count
  );
endinterface

// File: rtl/id_branch_resolve_cmp.sv
// B-type condition evaluator (combinational).
// Ports: i_rs1, i_rs2 operands; i_funct3 condition; o_taken.
module id_branch_resolve_cmp
  import id_branch_resolve_pkg::*;
(
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [2:0]  i_funct3,
  output logic        o_taken
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      FUNCT3_BEQ:  o_taken = w_eq;
      FUNCT3_BNE:  o_taken = ~w_eq;
      FUNCT3_BLT:  o_taken = w_lt;
      FUNCT3_BGE:  o_taken = ~w_lt;
      FUNCT3_BLTU: o_taken = w_ltu;
      FUNCT3_BGEU: o_taken = ~w_ltu;
      default:     o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_branch_resolve.sv
// Decode-stage branch resolution, hazard stall FSM, stats.
// Ports: clk, rst (sync, active-high); bus (slave modport).
module id_branch_resolve
  import id_branch_resolve_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  id_branch_resolve_if.slave bus
);

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_tk_cnt;

  logic        w_ctl;
  logic        w_use1;
  logic        w_use2;
  logic        w_m_ex;
  logic        w_m_mem;
  logic        w_h_alu;
  logic        w_h_ldex;
  logic        w_h_ldmem;
  logic        w_hazard;
  logic        w_stall_raw;
  logic        w_resolve;
  logic        w_cond;
  logic        w_taken;
  logic [31:0] w_pc_tgt;
  logic [31:0] w_jalr_sum;

  assign w_ctl = bus.id_valid
    & (bus.id_branch | bus.id_jal | bus.id_jalr);

  // JAL reads no registers, so it can never hazard
  assign w_use1 = bus.id_branch | bus.id_jalr;
  assign w_use2 = bus.id_branch;

  assign w_m_ex = (bus.ID_EX_rd != 5'd0)
    & ((w_use1 & (bus.id_rs1_addr == bus.ID_EX_rd))
     | (w_use2 & (bus.id_rs2_addr == bus.ID_EX_rd)));

  assign w_m_mem = (bus.EX_MEM_rd != 5'd0)
    & ((w_use1 & (bus.id_rs1_addr == bus.EX_MEM_rd))
     | (w_use2 & (bus.id_rs2_addr == bus.EX_MEM_rd)));

  assign w_h_alu = w_ctl & bus.ID_EX_regwrite
    & ~bus.ID_EX_memread & w_m_ex;
  assign w_h_ldex  = w_ctl & bus.ID_EX_memread & w_m_ex;
  assign w_h_ldmem = w_ctl & bus.EX_MEM_memread & w_m_mem;
  assign w_hazard  = w_h_alu | w_h_ldex | w_h_ldmem;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A load in EX needs two bubbles: S_WAIT covers the
  // second one without re-checking, since by then the
  // load has left MEM and its data is forwardable.
  always_comb begin
    w_state_nxt = r_state;
    w_stall_raw = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall_raw = w_hazard;
        if (w_h_ldex) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_stall_raw = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  id_branch_resolve_cmp u_cmp (
    .i_rs1    (bus.rs1_mod),
    .i_rs2    (bus.rs2_mod),
    .i_funct3 (bus.id_funct3),
    .o_taken  (w_cond)
  );

  assign w_resolve = w_ctl & (r_state == S_IDLE)
    & ~w_hazard & ~rst;

  always_comb begin
    w_taken = 1'b0;
    unique case (1'b1)
      bus.id_jal:    w_taken = 1'b1;
      bus.id_jalr:   w_taken = 1'b1;
      bus.id_branch: w_taken = w_cond;
      default:       w_taken = 1'b0;
    endcase
  end

  assign w_pc_tgt   = bus.id_pc + bus.id_imm;
  assign w_jalr_sum = bus.rs1_mod + bus.id_imm;

  assign bus.branch_target = bus.id_jalr
    ? {w_jalr_sum[31:1], 1'b0} : w_pc_tgt;

  assign bus.stall       = w_stall_raw & ~rst;
  assign bus.pc_src      = w_resolve & w_taken;
  assign bus.IF_ID_flush = w_resolve & w_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt <= '0;
      r_tk_cnt <= '0;
    end else if (w_resolve) begin
      if (r_br_cnt != '1)
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_taken && (r_tk_cnt != '1))
        r_tk_cnt <= r_tk_cnt + CNT_W'(1);
    end
  end

  assign bus.br_count       = r_br_cnt;
  assign bus.br_taken_count = r_tk_cnt;

endmodule

// File: tb/tb_id_branch_resolve.sv
// Testbench for id_branch_resolve: vector table, directed
// multi-cycle sequences and a randomized reference model.
module tb_id_branch_resolve;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_branch_resolve_if #(.CNT_W(CW)) bus ();

  id_branch_resolve #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] pc, imm;
    logic [4:0]  a1, a2;
    logic [31:0] v1, v2;
    logic [4:0]  exrd;
    logic        exrw, exmr;
    logic [4:0]  memrd;
    logic        memmr;
    logic        e_stall, e_src;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[$];

  logic [CW-1:0] m_cnt;
  logic [CW-1:0] m_tk;
  bit m_wait;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] c);
    return (c == CMAX) ? c : c + 1'b1;
  endfunction

  function automatic vec_t mk(
      input int kind, input logic [2:0] f3,
      input logic [31:0] pc, imm,
      input logic [4:0] a1, a2,
      input logic [31:0] v1, v2,
      input logic [4:0] exrd, input logic exrw, exmr,
      input logic [4:0] memrd, input logic memmr,
      input logic es, esrc, input logic [31:0] et);
    vec_t v;
    v.br = (kind == 1); v.jal = (kind == 2);
    v.jalr = (kind == 3);
    v.f3 = f3; v.pc = pc; v.imm = imm;
    v.a1 = a1; v.a2 = a2; v.v1 = v1; v.v2 = v2;
    v.exrd = exrd; v.exrw = exrw; v.exmr = exmr;
    v.memrd = memrd; v.memmr = memmr;
    v.e_stall = es; v.e_src = esrc; v.e_tgt = et;
    return v;
  endfunction

  task automatic idle_in();
    bus.id_valid = 1'b0; bus.id_branch = 1'b0;
    bus.id_jal = 1'b0; bus.id_jalr = 1'b0;
    bus.id_funct3 = 3'd0; bus.id_pc = '0; bus.id_imm = '0;
    bus.id_rs1_addr = '0; bus.id_rs2_addr = '0;
    bus.rs1_mod = '0; bus.rs2_mod = '0;
    bus.ID_EX_rd = '0; bus.ID_EX_regwrite = 1'b0;
    bus.ID_EX_memread = 1'b0;
    bus.EX_MEM_rd = '0; bus.EX_MEM_memread = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.id_valid = 1'b1;
    bus.id_branch = v.br; bus.id_jal = v.jal;
    bus.id_jalr = v.jalr; bus.id_funct3 = v.f3;
    bus.id_pc = v.pc; bus.id_imm = v.imm;
    bus.id_rs1_addr = v.a1; bus.id_rs2_addr = v.a2;
    bus.rs1_mod = v.v1; bus.rs2_mod = v.v2;
    bus.ID_EX_rd = v.exrd; bus.ID_EX_regwrite = v.exrw;
    bus.ID_EX_memread = v.exmr;
    bus.EX_MEM_rd = v.memrd; bus.EX_MEM_memread = v.memmr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference: condition truth straight from the ISA rules
  function automatic bit ref_cond(input logic [2:0] f3,
                                  input logic [31:0] a, b);
    int signed sa, sb;
    sa = a; sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic rand_cycle();
    bit ctl, u1, u2, mex, mmem, alu, ldex, ldmem, hz;
    bit e_stall, e_src, res, tk;
    logic [31:0] e_tgt;
    int kind;
    rst = ($urandom_range(0, 39) == 0);
    kind = $urandom_range(0, 3);
    bus.id_valid = ($urandom_range(0, 7) != 0);
    bus.id_branch = (kind == 1);
    bus.id_jal = (kind == 2);
    bus.id_jalr = (kind == 3);
    bus.id_funct3 = 3'($urandom_range(0, 7));
    bus.id_pc = $urandom;
    bus.id_imm = $urandom;
    bus.id_rs1_addr = 5'($urandom_range(0, 3));
    bus.id_rs2_addr = 5'($urandom_range(0, 3));
    bus.rs1_mod = ($urandom_range(0, 3) == 0)
      ? bus.rs2_mod : $urandom;
    bus.rs2_mod = $urandom;
    if ($urandom_range(0, 3) == 0) bus.rs1_mod = bus.rs2_mod;
    bus.ID_EX_rd = 5'($urandom_range(0, 3));
    bus.ID_EX_regwrite = $urandom_range(0, 1);
    bus.ID_EX_memread = ($urandom_range(0, 3) == 0);
    bus.EX_MEM_rd = 5'($urandom_range(0, 3));
    bus.EX_MEM_memread = ($urandom_range(0, 3) == 0);

    ctl = bus.id_valid && kind != 0;
    u1 = (kind == 1) || (kind == 3);
    u2 = (kind == 1);
    mex = bus.ID_EX_rd != 0 &&
      ((u1 && bus.id_rs1_addr == bus.ID_EX_rd) ||
       (u2 && bus.id_rs2_addr == bus.ID_EX_rd));
    mmem = bus.EX_MEM_rd != 0 &&
      ((u1 && bus.id_rs1_addr == bus.EX_MEM_rd) ||
       (u2 && bus.id_rs2_addr == bus.EX_MEM_rd));
    alu = ctl && bus.ID_EX_regwrite &&
      !bus.ID_EX_memread && mex;
    ldex = ctl && bus.ID_EX_memread && mex;
    ldmem = ctl && bus.EX_MEM_memread && mmem;
    hz = alu || ldex || ldmem;

    res = 1'b0; tk = 1'b0;
    e_stall = 1'b0;
    if (rst) e_stall = 1'b0;
    else if (m_wait) e_stall = 1'b1;
    else begin
      e_stall = hz;
      res = ctl && !hz;
      tk = res && (kind != 1 ||
        ref_cond(bus.id_funct3, bus.rs1_mod, bus.rs2_mod));
    end
    e_src = tk;
    if (kind == 3) e_tgt = (bus.rs1_mod + bus.id_imm) >> 1 << 1;
    else e_tgt = bus.id_pc + bus.id_imm;

    #1;
    chk("r_stall", 32'(bus.stall), 32'(e_stall));
    chk("r_pcsrc", 32'(bus.pc_src), 32'(e_src));
    chk("r_flush", 32'(bus.IF_ID_flush), 32'(e_src));
    if (e_src && bus.pc_src)
      chk("r_tgt", bus.branch_target, e_tgt);
    chk("r_cnt", 32'(bus.br_count), 32'(m_cnt));
    chk("r_tk", 32'(bus.br_taken_count), 32'(m_tk));

    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_cnt = '0; m_tk = '0;
    end else begin
      m_wait = !m_wait && ldex;
      if (res) m_cnt = sat(m_cnt);
      if (tk) m_tk = sat(m_tk);
    end
    #1;
  endtask

  initial begin
    vec_t v;
    idle_in();
    vecs.push_back(mk(1, 3'b000, 32'h100, 32'h20, 1, 2,
      5, 5, 0, 0, 0, 0, 0, 0, 1, 32'h120));
    vecs.push_back(mk(1, 3'b100, 32'h200, 32'h8, 1, 2,
      32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 1, 32'h208));
    vecs.push_back(mk(1, 3'b110, 32'h200, 32'h8, 1, 2,
      32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h40, 32'h8, 3, 4,
      7, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b101, 32'h300, 32'hFFFFFFF0, 1, 2,
      1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 1, 32'h2F0));
    vecs.push_back(mk(1, 3'b111, 32'h300, 32'h10, 1, 2,
      1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h300, 32'h10, 1, 2,
      1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 3'b000, 32'h80, 32'h4, 5, 0,
      32'h1001, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1004));
    vecs.push_back(mk(2, 3'b000, 32'h400, 32'h800, 5, 5,
      0, 0, 5, 1, 0, 0, 0, 0, 1, 32'hC00));
    vecs.push_back(mk(1, 3'b000, 32'h100, 32'h20, 1, 2,
      5, 5, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h100, 32'h20, 1, 2,
      5, 5, 0, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h500, 32'hC, 0, 0,
      0, 3, 0, 0, 1, 0, 0, 0, 1, 32'h50C));
    vecs.push_back(mk(3, 3'b000, 32'h0, 32'h0, 1, 6,
      32'h2003, 0, 6, 1, 0, 0, 0, 0, 1, 32'h2002));
    vecs.push_back(mk(1, 3'b110, 32'h10, 32'hFFFFFFFC, 1, 2,
      3, 5, 0, 0, 0, 0, 0, 0, 1, 32'hC));

    @(posedge clk);
    #1;
    #1;
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_pcsrc", 32'(bus.pc_src), 0);
    tick();
    rst = 1'b0;
    chk("rst_cnt", 32'(bus.br_count), 0);
    chk("rst_tk", 32'(bus.br_taken_count), 0);

    m_cnt = '0; m_tk = '0;
    foreach (vecs[i]) begin
      v = vecs[i];
      apply(v);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.stall),
          32'(v.e_stall));
      chk($sformatf("v%0d_pcsrc", i), 32'(bus.pc_src),
          32'(v.e_src));
      chk($sformatf("v%0d_flush", i), 32'(bus.IF_ID_flush),
          32'(v.e_src));
      if (v.e_src)
        chk($sformatf("v%0d_tgt", i), bus.branch_target,
            v.e_tgt);
      tick();
      if (!v.e_stall) m_cnt = sat(m_cnt);
      if (v.e_src) m_tk = sat(m_tk);
      chk($sformatf("v%0d_cnt", i), 32'(bus.br_count),
          32'(m_cnt));
      chk($sformatf("v%0d_tk", i), 32'(bus.br_taken_count),
          32'(m_tk));
    end
    idle_in();
    tick();

    // Load in EX feeding BNE: two bubbles then resolve
    do_reset();
    apply(mk(1, 3'b001, 32'h600, 32'h10, 3, 4,
      1, 2, 3, 1, 1, 0, 0, 0, 0, 0));
    #1;
    chk("ld_c1_stall", 32'(bus.stall), 1);
    chk("ld_c1_pcsrc", 32'(bus.pc_src), 0);
    tick();
    bus.ID_EX_rd = '0; bus.ID_EX_regwrite = 1'b0;
    bus.ID_EX_memread = 1'b0;
    bus.EX_MEM_rd = 5'd3; bus.EX_MEM_memread = 1'b1;
    #1;
    chk("ld_c2_stall", 32'(bus.stall), 1);
    chk("ld_c2_pcsrc", 32'(bus.pc_src), 0);
    tick();
    bus.EX_MEM_rd = '0; bus.EX_MEM_memread = 1'b0;
    #1;
    chk("ld_c3_stall", 32'(bus.stall), 0);
    chk("ld_c3_pcsrc", 32'(bus.pc_src), 1);
    chk("ld_c3_tgt", bus.branch_target, 32'h610);
    tick();
    chk("ld_cnt", 32'(bus.br_count), 1);

    // id_valid drops while waiting: back to idle, no resolve
    apply(mk(1, 3'b000, 32'h0, 32'h4, 7, 0,
      0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
    tick();
    idle_in();
    #1;
    chk("drop_wait_stall", 32'(bus.stall), 1);
    tick();
    chk("drop_idle_stall", 32'(bus.stall), 0);
    chk("drop_cnt", 32'(bus.br_count), 1);

    // Reset while in S_WAIT
    apply(mk(1, 3'b000, 32'h0, 32'h4, 7, 0,
      0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
    tick();
    rst = 1'b1;
    idle_in();
    #1;
    chk("rstw_stall_in_rst", 32'(bus.stall), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstw_stall", 32'(bus.stall), 0);
    chk("rstw_cnt", 32'(bus.br_count), 0);
    chk("rstw_tk", 32'(bus.br_taken_count), 0);

    // Saturation: more taken jumps than the counters hold
    for (int k = 0; k < 20; k++) begin
      apply(mk(2, 3'b000, 32'h1000, 32'h10, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1010));
      tick();
    end
    chk("sat_cnt", 32'(bus.br_count), 32'(CMAX));
    chk("sat_tk", 32'(bus.br_taken_count), 32'(CMAX));
    apply(mk(1, 3'b000, 32'h0, 32'h4, 1, 2,
      1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    chk("sat_cnt2", 32'(bus.br_count), 32'(CMAX));
    chk("sat_tk2", 32'(bus.br_taken_count), 32'(CMAX));

    // Randomized run against the reference model
    do_reset();
    m_wait = 0; m_cnt = '0; m_tk = '0;
    for (int k = 0; k < 3000; k++) rand_cycle();

    rst = 1'b0;
    idle_in();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
